clk_rst_gen: RTL

Reset generator driving the source side of the `clk_rst` interface: takes the board clock and raw asynchronous reset and produces the four distributed reset flavours consumed by `clk_rst` sinks. `ARST_O` is asserted asynchronously and released synchronously. `SRST_O` is a fully synchronous reset stretched past `ARST_O` release, with an optional software-requested synchronous reset pulse. Sits at the top level next to the clock source; one instance per clock domain.

---
 rtl/clk_rst_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clk_rst_gen.sv
// ============================================================================
//  Module   : clk_rst_gen
//  Purpose  : Per-domain reset generator. Produces an async-assert /
//             sync-release reset pair (ARST_O / ARSTn_O) and a stretched,
//             fully synchronous reset pair (SRST_O / SRSTn_O). The software
//             reset request path and SW_RST_ACK exist only when
//             CLK_RST_GEN_SWRST_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_rst_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 16,
  parameter int SW_PULSE_CYCLES = 8
) (
  input  logic CLK,
  input  logic ARST,
  input  logic SW_RST_REQ,
  output logic CLK_O,
  output logic ARST_O,
  output logic ARSTn_O,
  output logic SRST_O,
  output logic SRSTn_O,
  output logic SW_RST_ACK
);

  // The counter only ever has to reach the larger of the two terminal counts.
  localparam int c_max_cycles = (HOLD_CYCLES > SW_PULSE_CYCLES) ? HOLD_CYCLES : SW_PULSE_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
`ifdef CLK_RST_GEN_SWRST_EN
  localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(SW_PULSE_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
`ifdef CLK_RST_GEN_SWRST_EN
    , ST_SWRST = 2'd3
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] arst_sync_q;
  logic [SYNC_STAGES-1:0] arstn_sync_q;
  state_t                 state_q;
  logic [c_cnt_w-1:0]     cnt_q;
  logic                   srst_q;
  logic                   srstn_q;

  assign CLK_O = CLK;

  // Active-high reset synchronizer: set asynchronously, drains to 0 on release.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      arst_sync_q <= '1;
    end else begin
      arst_sync_q <= {arst_sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  // Independent active-low chain so ARSTn_O is a flop output, not an inverter.
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      arstn_sync_q <= '0;
    end else begin
      arstn_sync_q <= {arstn_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ARST_O  = arst_sync_q[SYNC_STAGES-1];
  assign ARSTn_O = arstn_sync_q[SYNC_STAGES-1];

`ifdef CLK_RST_GEN_SWRST_EN
  logic req_q;
  logic req_prev_q;
  logic ack_q;
  logic req_rise;

  // Request edge detect. Both flops reset to 1 so a request held high through
  // reset never looks like a rising edge. The extra sampling flop places the
  // SWRST entry one edge after the request is first sampled.
  always_ff @(posedge CLK or posedge ARST_O) begin
    if (ARST_O) begin
      req_q      <= 1'b1;
      req_prev_q <= 1'b1;
    end else begin
      req_q      <= SW_RST_REQ;
      req_prev_q <= req_q;
    end
  end

  assign req_rise   = req_q & ~req_prev_q;
  assign SW_RST_ACK = ack_q;
`else
  logic unused_sw_req;
  assign unused_sw_req = SW_RST_REQ;
  assign SW_RST_ACK    = 1'b0;
`endif

  // Reset sequencing FSM; reset by the synchronized reset so every release is
  // clean. Outputs are registered alongside the state.
  always_ff @(posedge CLK or posedge ARST_O) begin
    if (ARST_O) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      srst_q  <= 1'b1;
      srstn_q <= 1'b0;
`ifdef CLK_RST_GEN_SWRST_EN
      ack_q   <= 1'b0;
`endif
    end else begin
`ifdef CLK_RST_GEN_SWRST_EN
      ack_q <= 1'b0;
`endif
      case (state_q)
        // Any edge reaching here has ARST_O low: start stretching.
        ST_HOLD: begin
          state_q <= ST_STRETCH;
          cnt_q   <= '0;
        end
        ST_STRETCH: begin
          if (cnt_q == c_hold_last) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            srst_q  <= 1'b0;
            srstn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
`ifdef CLK_RST_GEN_SWRST_EN
          if (req_rise) begin
            state_q <= ST_SWRST;
            cnt_q   <= '0;
            srst_q  <= 1'b1;
            srstn_q <= 1'b0;
          end
`endif
        end
`ifdef CLK_RST_GEN_SWRST_EN
        ST_SWRST: begin
          if (cnt_q == c_pulse_last) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            srst_q  <= 1'b0;
            srstn_q <= 1'b1;
            ack_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
          srst_q  <= 1'b1;
          srstn_q <= 1'b0;
        end
      endcase
    end
  end

  assign SRST_O  = srst_q;
  assign SRSTn_O = srstn_q;

endmodule

`default_nettype wire
